// File: rtl/pc_unit_if.sv
// Controller-facing bundle of the PC unit: next-PC controls in, PC/EPC/RAS state out.
interface pc_unit_if #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int PW = ADDR_W - 2;
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic          PCWr;
    logic [1:0]    npc_sel;
    logic [15:0]   imm16;
    logic [25:0]   target26;
    logic [PW-1:0] jr_addr;
    logic          exc;
    logic          eret;
    logic          call;
    logic          ret;
    logic [PW-1:0] PC;
    logic [PW-1:0] PC_plus1;
    logic [PW-1:0] EPC;
    logic [PW-1:0] ras_top;
    logic [CW-1:0] ras_cnt;

    modport master (
        output PCWr, npc_sel, imm16, target26, jr_addr, exc, eret, call, ret,
        input  PC, PC_plus1, EPC, ras_top, ras_cnt
    );

    modport slave (
        input  PCWr, npc_sel, imm16, target26, jr_addr, exc, eret, call, ret,
        output PC, PC_plus1, EPC, ras_top, ras_cnt
    );
endinterface

// File: rtl/pc_unit.sv
// Word-addressed program counter with next-PC selection, exception entry/return
// and a circular return-address stack for fetch-side return prediction.
module pc_unit #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4
) (
    input logic       clk,
    input logic       rst,
    pc_unit_if.slave  bus
);
    localparam int PW   = ADDR_W - 2;
    localparam int PTRW = $clog2(RAS_DEPTH);
    localparam int CW   = PTRW + 1;

    localparam logic [PW-1:0] RESET_WORD = RESET_PC[ADDR_W-1:2];
    localparam logic [PW-1:0] EXC_WORD   = EXC_VEC[ADDR_W-1:2];
    localparam logic [CW-1:0] RAS_FULL   = CW'(RAS_DEPTH);

    logic [PW-1:0]   pc_q, pc_d;
    logic [PW-1:0]   epc_q, epc_d;
    logic [PTRW-1:0] rasPtr_q, rasPtr_d;
    logic [CW-1:0]   rasCnt_q, rasCnt_d;
    logic [PW-1:0]   rasMem_q [RAS_DEPTH];
    logic            rasWe;
    logic [PTRW-1:0] rasWaddr;

    logic [PW-1:0] pcPlus1;
    logic [PW-1:0] branchNpc;
    logic [PW-1:0] jumpNpc;
    logic [PW-1:0] npc;

    assign pcPlus1   = pc_q + 1'b1;
    assign branchNpc = pcPlus1 + {{(PW-16){bus.imm16[15]}}, bus.imm16};

    // At ADDR_W=28 the jump target covers the whole word address.
    generate
        if (PW > 26) begin : gJumpWide
            assign jumpNpc = {pcPlus1[PW-1:26], bus.target26};
        end else begin : gJumpFull
            assign jumpNpc = bus.target26;
        end
    endgenerate

    always_comb begin
        npc = pcPlus1;
        case (bus.npc_sel)
            2'd0:    npc = pcPlus1;
            2'd1:    npc = branchNpc;
            2'd2:    npc = jumpNpc;
            default: npc = bus.jr_addr;
        endcase
    end

    // Pointer addresses the current top; a push past full simply wraps over the oldest.
    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        rasPtr_d = rasPtr_q;
        rasCnt_d = rasCnt_q;
        rasWe    = 1'b0;
        rasWaddr = rasPtr_q;
        if (bus.exc) begin
            pc_d  = EXC_WORD;
            epc_d = pc_q;
        end else if (bus.eret) begin
            pc_d = epc_q;
        end else if (bus.PCWr) begin
            pc_d = npc;
            if (bus.call && bus.ret && rasCnt_q != '0) begin
                rasWe    = 1'b1;
                rasWaddr = rasPtr_q;
            end else if (bus.call) begin
                rasWe    = 1'b1;
                rasWaddr = rasPtr_q + 1'b1;
                rasPtr_d = rasPtr_q + 1'b1;
                if (rasCnt_q != RAS_FULL) begin
                    rasCnt_d = rasCnt_q + 1'b1;
                end
            end else if (bus.ret && rasCnt_q != '0) begin
                rasPtr_d = rasPtr_q - 1'b1;
                rasCnt_d = rasCnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_WORD;
            epc_q    <= '0;
            rasPtr_q <= '0;
            rasCnt_q <= '0;
        end else begin
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            rasPtr_q <= rasPtr_d;
            rasCnt_q <= rasCnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rasWe) begin
            rasMem_q[rasWaddr] <= pcPlus1;
        end
    end

    assign bus.PC       = pc_q;
    assign bus.PC_plus1 = pcPlus1;
    assign bus.EPC      = epc_q;
    assign bus.ras_top  = (rasCnt_q == '0) ? '0 : rasMem_q[rasPtr_q];
    assign bus.ras_cnt  = rasCnt_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit at default parameters
// (ADDR_W=32, RESET_PC=0x3000, EXC_VEC=0x4180, RAS_DEPTH=4).
module tb_pc_unit;
    typedef struct {
        logic        rst;
        logic        pcwr;
        logic [1:0]  sel;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [29:0] jr;
        logic        exc;
        logic        eret;
        logic        call;
        logic        ret;
        logic [29:0] ePc;
        logic [29:0] eEpc;
        logic [29:0] eTop;
        logic [2:0]  eCnt;
    } vec_t;

    logic clk;
    logic rst;
    int   vecCount;
    int   missCount;
    vec_t vecs[$];

    pc_unit_if #(.ADDR_W(32), .RAS_DEPTH(4)) bus ();

    pc_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_3000),
        .EXC_VEC  (32'h0000_4180),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic w, input logic [1:0] s,
                          input logic [15:0] im, input logic [25:0] tg, input logic [29:0] j,
                          input logic ex, input logic er, input logic ca, input logic re,
                          input logic [29:0] pc, input logic [29:0] epc,
                          input logic [29:0] top, input logic [2:0] cnt);
        vec_t v;
        v.rst = r;  v.pcwr = w;  v.sel = s;  v.imm = im;  v.tgt = tg;  v.jr = j;
        v.exc = ex; v.eret = er; v.call = ca; v.ret = re;
        v.ePc = pc; v.eEpc = epc; v.eTop = top; v.eCnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [29:0] ePc, input logic [29:0] eEpc,
                               input logic [29:0] eTop, input logic [2:0] eCnt);
        logic [29:0] ePlus1;
        ePlus1 = ePc + 30'd1;
        checkVal({tag, ".PC"},       {2'b00, bus.PC},       {2'b00, ePc});
        checkVal({tag, ".PC_plus1"}, {2'b00, bus.PC_plus1}, {2'b00, ePlus1});
        checkVal({tag, ".EPC"},      {2'b00, bus.EPC},      {2'b00, eEpc});
        checkVal({tag, ".ras_top"},  {2'b00, bus.ras_top},  {2'b00, eTop});
        checkVal({tag, ".ras_cnt"},  {29'd0, bus.ras_cnt},  {29'd0, eCnt});
    endtask

    task automatic applyStimulus(input vec_t v);
        rst          = v.rst;
        bus.PCWr     = v.pcwr;
        bus.npc_sel  = v.sel;
        bus.imm16    = v.imm;
        bus.target26 = v.tgt;
        bus.jr_addr  = v.jr;
        bus.exc      = v.exc;
        bus.eret     = v.eret;
        bus.call     = v.call;
        bus.ret      = v.ret;
    endtask

    initial begin
        vec_t idle;
        vecCount  = 0;
        missCount = 0;
        idle = '{rst: 1'b0, pcwr: 1'b0, sel: 2'd0, imm: 16'h0, tgt: 26'h0, jr: 30'h0,
                 exc: 1'b0, eret: 1'b0, call: 1'b0, ret: 1'b0,
                 ePc: 30'h0, eEpc: 30'h0, eTop: 30'h0, eCnt: 3'd0};
        applyStimulus(idle);

        //     rst w sel imm       tgt      jr            ex er ca re  PC            EPC     top     cnt
        addVec(1, 0, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 0, 0, 30'h0C00,     30'h0,  30'h0,  3'd0);
        addVec(1, 0, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 0, 0, 30'h0C00,     30'h0,  30'h0,  3'd0);
        addVec(0, 0, 1, 16'h0005, 26'h0,   30'h0,        0, 0, 0, 0, 30'h0C00,     30'h0,  30'h0,  3'd0);
        addVec(0, 0, 2, 16'h0000, 26'h5,   30'h0,        0, 0, 1, 0, 30'h0C00,     30'h0,  30'h0,  3'd0);
        addVec(0, 0, 3, 16'h0000, 26'h0,   30'h77,       0, 0, 0, 1, 30'h0C00,     30'h0,  30'h0,  3'd0);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 0, 0, 30'h0C01,     30'h0,  30'h0,  3'd0);
        addVec(0, 1, 1, 16'hFFFE, 26'h0,   30'h0,        0, 0, 0, 0, 30'h0C00,     30'h0,  30'h0,  3'd0);
        addVec(0, 1, 1, 16'h0010, 26'h0,   30'h0,        0, 0, 0, 0, 30'h0C11,     30'h0,  30'h0,  3'd0);
        addVec(1, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 0, 0, 30'h0C00,     30'h0,  30'h0,  3'd0);
        addVec(0, 1, 2, 16'h0000, 26'h0FF, 30'h0,        0, 0, 0, 0, 30'h00FF,     30'h0,  30'h0,  3'd0);
        addVec(0, 1, 3, 16'h0000, 26'h0,   30'h3FFFFFFF, 0, 0, 0, 0, 30'h3FFFFFFF, 30'h0,  30'h0,  3'd0);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 0, 0, 30'h0,        30'h0,  30'h0,  3'd0);
        addVec(0, 1, 3, 16'h0000, 26'h0,   30'h0C05,     0, 0, 0, 0, 30'h0C05,     30'h0,  30'h0,  3'd0);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        1, 0, 1, 0, 30'h1060,     30'hC05, 30'h0, 3'd0);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 1, 1, 0, 30'h0C05,     30'hC05, 30'h0, 3'd0);
        addVec(0, 0, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 1, 0, 30'h0C05,     30'hC05, 30'h0, 3'd0);
        addVec(1, 0, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 0, 0, 30'h0C00,     30'h0,  30'h0,  3'd0);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 1, 0, 30'h0C01,     30'h0,  30'hC01, 3'd1);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 1, 0, 30'h0C02,     30'h0,  30'hC02, 3'd2);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 1, 0, 30'h0C03,     30'h0,  30'hC03, 3'd3);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 1, 0, 30'h0C04,     30'h0,  30'hC04, 3'd4);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 1, 0, 30'h0C05,     30'h0,  30'hC05, 3'd4);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 0, 1, 30'h0C06,     30'h0,  30'hC04, 3'd3);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 0, 1, 30'h0C07,     30'h0,  30'hC03, 3'd2);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 0, 1, 30'h0C08,     30'h0,  30'hC02, 3'd1);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 0, 1, 30'h0C09,     30'h0,  30'h0,  3'd0);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 0, 1, 30'h0C0A,     30'h0,  30'h0,  3'd0);
        addVec(0, 1, 3, 16'h0000, 26'h0,   30'h0C0E,     0, 0, 0, 0, 30'h0C0E,     30'h0,  30'h0,  3'd0);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 1, 0, 30'h0C0F,     30'h0,  30'hC0F, 3'd1);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 1, 0, 30'h0C10,     30'h0,  30'hC10, 3'd2);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 1, 1, 30'h0C11,     30'h0,  30'hC11, 3'd2);
        addVec(0, 0, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 1, 1, 30'h0C11,     30'h0,  30'hC11, 3'd2);
        addVec(1, 0, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 0, 0, 30'h0C00,     30'h0,  30'h0,  3'd0);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 0, 1, 1, 30'h0C01,     30'h0,  30'hC01, 3'd1);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        1, 0, 0, 1, 30'h1060,     30'hC01, 30'hC01, 3'd1);
        addVec(0, 1, 0, 16'h0000, 26'h0,   30'h0,        0, 1, 0, 1, 30'h0C01,     30'hC01, 30'hC01, 3'd1);
        addVec(1, 1, 0, 16'h0000, 26'h0,   30'h0,        1, 0, 1, 0, 30'h0C00,     30'h0,  30'h0,  3'd0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eEpc, vecs[i].eTop, vecs[i].eCnt);
        end

        // PC must not follow its inputs before the clock edge.
        applyStimulus(idle);
        bus.PCWr    = 1'b1;
        bus.npc_sel = 2'd3;
        bus.jr_addr = 30'h3FFF_FFFF;
        #2;
        checkVal("seq.noCombPath.PC", {2'b00, bus.PC}, 32'h0000_0C00);
        @(posedge clk);
        #1;
        checkVal("seq.allOnes.PC", {2'b00, bus.PC}, 32'h3FFF_FFFF);
        checkVal("seq.allOnes.PC_plus1", {2'b00, bus.PC_plus1}, 32'h0);
        bus.npc_sel = 2'd1;
        bus.imm16   = 16'h0003;
        @(posedge clk);
        #1;
        checkVal("seq.branchWrap.PC", {2'b00, bus.PC}, 32'h0000_0003);

        // Several idle cycles with stray call/ret leave everything held.
        applyStimulus(idle);
        bus.call = 1'b1;
        bus.ret  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("seq.hold", 30'h3, 30'h0, 30'h0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter block for the multi-cycle MIPS datapath. It supersedes the bare PC register.
- Holds the word-addressed PC and computes the next PC internally: sequential, branch, jump or register jump.
- Adds exception entry with an EPC register, ERET return, and a small return-address stack (RAS) that supplies return-target prediction to fetch.
- Sits between the controller (PCWr, npc_sel, exc, eret, call, ret) and instruction memory (PC).

Parameters:
- ADDR_W, 32, byte-address width. Legal range 28..32. PC is held as word address bits [ADDR_W-1:2].
- RESET_PC, 32'h0000_3000, byte address loaded on reset. Bits [1:0] are ignored.
- EXC_VEC, 32'h0000_4180, byte address of the exception handler. Bits [1:0] are ignored.
- RAS_DEPTH, 4, number of RAS entries. Must be a power of 2, range 2..16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- PCWr  in  1  PC write enable for normal next-PC update.
- npc_sel  in  2  next-PC source: 0 = seq, 1 = branch, 2 = jump, 3 = jr.
- imm16  in  16  branch word offset, signed.
- target26  in  26  jump word target.
- jr_addr  in  ADDR_W-2  register-jump word address.
- exc  in  1  exception request.
- eret  in  1  return from exception.
- call  in  1  push the return address (valid only with PCWr).
- ret  in  1  pop the RAS (valid only with PCWr).
- PC  out  ADDR_W-2  current word PC.
- PC_plus1  out  ADDR_W-2  combinational PC+1, modulo 2^(ADDR_W-2).
- EPC  out  ADDR_W-2  saved exception PC.
- ras_top  out  ADDR_W-2  top RAS entry; 0 when the RAS is empty.
- ras_cnt  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.

Behaviour:
- Reset (rst=1 at a clock edge), all other inputs ignored:
  - PC = RESET_PC[ADDR_W-1:2].
  - EPC = 0.
  - RAS pointer = 0, ras_cnt = 0, ras_top = 0.
  - RAS entries are don't-care.
- Update priority per edge: rst > exc > eret > PCWr > hold.
- exc=1:
  - PC <= EXC_VEC[ADDR_W-1:2].
  - EPC <= current PC.
  - PCWr, eret, call and ret are ignored; the RAS is unchanged.
- eret=1 (and exc=0):
  - PC <= EPC; EPC is unchanged.
  - PCWr, call and ret are ignored.
- PCWr=1 (no exc, no eret), PC <= NPC:
  - sel 0: NPC = PC+1.
  - sel 1: NPC = PC+1 + sign-extend(imm16) to ADDR_W-2 bits, modulo 2^(ADDR_W-2).
  - sel 2: NPC = {PC_plus1[ADDR_W-3:26], target26}. For ADDR_W=28 this is target26 alone.
  - sel 3: NPC = jr_addr.
- PCWr=0 (no exc, no eret): PC holds; call and ret are ignored.
- Wrap: PC+1 at all-ones wraps to 0 without error.
- The PC register has single-cycle latency. The new PC is visible the cycle after the edge; no combinational path from inputs to PC.
- RAS (updates only when PCWr=1, exc=0, eret=0), stored as a circular buffer:
  - call only: push PC_plus1. If full, the oldest entry is overwritten and ras_cnt stays at RAS_DEPTH.
  - ret only: pop. If empty, no change; ras_cnt does not underflow.
  - call and ret together: top entry is replaced by PC_plus1; ras_cnt is unchanged. If empty, this acts as a push.
  - ras_top reads the entry at the current pointer, combinationally from registered state.
- Reset mid-operation (for example during a pending exception) discards all state; PC returns to RESET_PC next cycle.

Test Plan:
- Reset with defaults: rst=1 for 2 cycles, then PCWr=0 → PC=0x0C00 (byte 0x3000), EPC=0, ras_cnt=0. PC holds 0x0C00 for 3 idle cycles.
- Sequential and branch: from PC=0x0C00, PCWr=1, sel=0 → 0x0C01. Then sel=1 with imm16=16'hFFFE → 0x0C00. Then imm16=16'h0010 → 0x0C11.
- Jump and jr:
  - PC=0x0C00, sel=2, target26=26'h0000_0FF → PC=0x00FF.
  - sel=3, jr_addr=0x3FFF_FFFF → PC=0x3FFF_FFFF.
  - Then sel=0 → PC wraps to 0.
- Exception precedence: PC=0x0C05 with exc=1, PCWr=1, call=1 in the same cycle → PC=0x1060, EPC=0x0C05, ras_cnt unchanged. Then eret=1 → PC=0x0C05.
- RAS, RAS_DEPTH=4, starting at PC=0x0C00:
  - 5 consecutive PCWr+call with sel=0 → ras_cnt saturates at 4; ras_top=0x0C05 (first push, 0x0C01, overwritten).
  - Then 5 PCWr+ret → ras_top sequence 0x0C04, 0x0C03, 0x0C02, then 0; ras_cnt stops at 0.
- Simultaneous call+ret with ras_cnt=2, PC=0x0C10, PCWr=1 → ras_top=0x0C11, ras_cnt=2. The same stimulus with PCWr=0 → no change.
